// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Brief    : ALU function codes, legality check and response record shared by
//            the ALU arbiter and its sub-blocks.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    // ALU function codes; anything above aluSLTU is undefined
    localparam logic [3:0] aluAdd  = 4'd0;
    localparam logic [3:0] aluSub  = 4'd1;
    localparam logic [3:0] aluAnd  = 4'd2;
    localparam logic [3:0] aluOr   = 4'd3;
    localparam logic [3:0] aluXor  = 4'd4;
    localparam logic [3:0] aluNor  = 4'd5;
    localparam logic [3:0] aluSLL  = 4'd6;
    localparam logic [3:0] aluSRL  = 4'd7;
    localparam logic [3:0] aluSRA  = 4'd8;
    localparam logic [3:0] aluSLT  = 4'd9;
    localparam logic [3:0] aluSLTU = 4'd10;

    // Contents of the single-entry response buffer
    typedef struct packed {
        logic [31:0] y;
        logic        id;
        logic        ovf;
        logic        err;
    } rsp_t;

    // True for the eleven function codes the ALU implements
    function automatic logic alu_func_valid(input logic [3:0] func);
        logic ok;
        case (func)
            aluAdd, aluSub, aluAnd, aluOr, aluXor, aluNor,
            aluSLL, aluSRL, aluSRA, aluSLT, aluSLTU: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Bundle of requester, ALU and response signals around the shared
//            ALU. slave = arbiter view, master = surrounding system view.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [3:0]       req0_func;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [3:0]       req1_func;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_func;
    logic [31:0]      alu_y;
    logic             alu_ovf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [31:0]      rsp_y;
    logic             rsp_ovf;
    logic             rsp_err;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_func,
        input  req1_valid, req1_a, req1_b, req1_func,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_func,
        input  alu_y, alu_ovf,
        output rsp_valid, rsp_id, rsp_y, rsp_ovf, rsp_err,
        input  rsp_ready,
        output grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_func,
        output req1_valid, req1_a, req1_b, req1_func,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_func,
        output alu_y, alu_ovf,
        input  rsp_valid, rsp_id, rsp_y, rsp_ovf, rsp_err,
        output rsp_ready,
        input  grant_cnt0, grant_cnt1
    );
endinterface : alu_arbiter_if
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_rr_arb2
// Brief    : Combinational 2-way round-robin arbiter. On a conflict the
//            requester that did not win last time is granted.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_rr_arb2 (
    input  wire logic valid0_i,
    input  wire logic valid1_i,
    input  wire logic enable_i,
    input  wire logic last_grant_i,
    output logic      grant0_o,
    output logic      grant1_o
);

    // Lone requester wins; on a tie the one that was not last granted wins
    always_comb begin
        grant0_o = enable_i & valid0_i & (~valid1_i |  last_grant_i);
        grant1_o = enable_i & valid1_i & (~valid0_i | ~last_grant_i);
    end

endmodule : alu_arbiter_rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one combinational ALU between two requesters with
//            round-robin arbitration, a single-entry response buffer,
//            illegal-code/overflow flags and saturating grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter bit OVF_EN = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    alu_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             can_issue;
    logic             rsp_valid;
    logic             grant0;
    logic             grant1;
    logic             issue;
    logic             last_grant_q;
    logic [3:0]       sel_func;
    rsp_t             rsp_q;
    rsp_t             rsp_d;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    alu_arbiter_rr_arb2 u_arb (
        .valid0_i     (bus.req0_valid),
        .valid1_i     (bus.req1_valid),
        .enable_i     (can_issue),
        .last_grant_i (last_grant_q),
        .grant0_o     (grant0),
        .grant1_o     (grant1)
    );

    assign issue = grant0 | grant1;

    // Operand steering: requester 0 drives the ALU whenever requester 1 is not granted
    assign sel_func     = grant1 ? bus.req1_func : bus.req0_func;
    assign bus.alu_a    = grant1 ? bus.req1_a    : bus.req0_a;
    assign bus.alu_b    = grant1 ? bus.req1_b    : bus.req0_b;
    assign bus.alu_func = sel_func;

    // Buffer occupancy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // A new grant always refills; otherwise a taken response empties the buffer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (issue) state_d = ST_FULL;
            ST_FULL: begin
                if (issue)              state_d = ST_FULL;
                else if (bus.rsp_ready) state_d = ST_EMPTY;
            end
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Issue is allowed into an empty buffer or one that drains this cycle
    always_comb begin
        rsp_valid = (state_q == ST_FULL);
        can_issue = (state_q == ST_EMPTY) || bus.rsp_ready;
    end

    // Next response: illegal codes zero the result; overflow only counts for add/sub
    always_comb begin
        rsp_d.id  = grant1;
        rsp_d.err = ~alu_func_valid(sel_func);
        rsp_d.y   = rsp_d.err ? 32'd0 : bus.alu_y;
        rsp_d.ovf = OVF_EN & bus.alu_ovf & ((sel_func == aluAdd) || (sel_func == aluSub));
    end

    // Response payload and round-robin pointer capture on every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_q        <= '0;
            last_grant_q <= 1'b1;
        end else if (issue) begin
            rsp_q        <= rsp_d;
            last_grant_q <= grant1;
        end
    end

    // Saturating per-requester grant counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
            if (grant1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_q.id;
    assign bus.rsp_y      = rsp_q.y;
    assign bus.rsp_ovf    = rsp_q.ovf;
    assign bus.rsp_err    = rsp_q.err;
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;

endmodule : alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu instance between two requesters: requester 0 is the execute stage and requester 1 is the multi-cycle/auxiliary unit. The block does round-robin arbitration, drives the ALU operands and function code, and registers the result into a single-entry response buffer with a valid/ready handshake. It also flags illegal function codes, qualifies overflow, and keeps saturating per-requester grant counters for performance debug.

Parameters:
CNT_W, 16, width of each saturating grant counter
OVF_EN, 1, 1 = report overflow on add/sub; 0 = rsp_ovf tied low

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  32  requester 0 operand A
req0_b  input  32  requester 0 operand B
req0_func  input  4  requester 0 ALU function code
req1_valid / req1_ready / req1_a / req1_b / req1_func  same as requester 0, for requester 1
alu_a  output  32  operand A to alu
alu_b  output  32  operand B to alu
alu_func  output  4  function code to alu
alu_y  input  32  alu result
alu_ovf  input  1  alu overflow flag
rsp_valid  output  1  response buffer holds a result
rsp_ready  input  1  consumer takes the response
rsp_id  output  1  requester that owns the response
rsp_y  output  32  registered result
rsp_ovf  output  1  qualified overflow
rsp_err  output  1  illegal function code was issued
grant_cnt0  output  CNT_W  grants to requester 0, saturating
grant_cnt1  output  CNT_W  grants to requester 1, saturating

Behaviour:
- Reset (asynchronous, effective immediately): rsp_valid=0, rsp_id=0, rsp_y=0, rsp_ovf=0, rsp_err=0, grant counters=0, last_grant=1, so requester 0 wins the first conflict. An in-flight response is discarded and never re-delivered.
- Buffer state is EMPTY or FULL. The block may accept an operation (can_issue) when the state is EMPTY, or when it is FULL and rsp_ready=1 (same-cycle drain and refill).
- Arbitration is combinational:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - If can_issue=0, no requester is granted.
- reqN_ready = grantN. A ready is never asserted without the matching valid.
- alu_a, alu_b and alu_func come from the granted requester. When there is no grant they come from requester 0, so the ALU inputs never float.
- On a grant edge:
  - rsp_y is loaded with alu_y.
  - rsp_id is loaded with the granted requester.
  - rsp_err = 1 if func is not one of the 11 defined alu function codes; in that case rsp_y is forced to 0.
  - rsp_ovf = OVF_EN & alu_ovf & (func is aluAdd or aluSub). Overflow is never reported for other functions.
  - rsp_valid is set to 1 and last_grant is updated.
  - The granted requester's counter increments and holds at all-ones.
- Latency: an operation accepted at edge N is visible on rsp_* after edge N; rsp_valid is high in cycle N+1.
- rsp_valid=1 and rsp_ready=1 with no new grant: rsp_valid falls to 0 and the rsp_* data holds its last value.
- rsp_valid=1 and rsp_ready=0: rsp_* is stable and both reqN_ready stay 0 (backpressure).
- Requester inputs may change freely while that requester is not granted. A requester must hold valid and operands until it sees ready.
- Throughput: one operation per cycle while the consumer keeps rsp_ready high.

Decomposition:
- The alu function codes (aluAdd … aluSLTU) come from constants.v. Add an aluFuncValid-style macro or function there that lists the 11 legal codes.
- One sub-module is natural: rr_arb2, the 2-way round-robin arbiter (valid0, valid1, enable, last_grant → grant0, grant1).
- The response buffer and the saturating counters stay in the top level.

Test Plan:
- Basic issue:
  - Stimulus: req0 aluAdd with A=5, B=7 while idle.
  - Required response: req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_y=12, rsp_ovf=0, rsp_err=0.
- Conflict and fairness:
  - Stimulus: both requesters valid continuously, rsp_ready=1, req0 aluSub 10-3, req1 aluOr 0xF0|0x0F.
  - Required response: responses alternate id 0,1,0,1 starting with 0, with rsp_y 7 and 0xFF; grant_cnt0 and grant_cnt1 differ by at most 1.
- Overflow qualification:
  - Stimulus: req1 aluAdd 0x7FFFFFFF+1 gives rsp_ovf=1 and rsp_y=0x80000000. Then aluSLT with alu_ovf forced to 1 in the bench gives rsp_ovf=0.
  - Required response: repeat with OVF_EN=0 and rsp_ovf stays 0 in both cases.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 3 cycles with both requesters valid.
  - Required response: both ready signals stay 0 and rsp_* is stable. On the rsp_ready=1 cycle, the drain and the next grant happen in the same cycle, and the new result appears on the following cycle.
- Illegal code:
  - Stimulus: req0_func set to an undefined code, with A=1, B=1.
  - Required response: rsp_err=1, rsp_y=0, rsp_ovf=0.
- Reset mid-operation and saturation:
  - Stimulus: assert reset while rsp_valid=1, then run again with CNT_W=2 and 5 grants to req0.
  - Required response: reset drops rsp_valid and zeroes the counters with no clock edge needed, and the next conflict grants req0. With CNT_W=2, grant_cnt0 saturates at 3.
